// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake core.
// Heading encoding and the reversal helper.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter,
// debounced level and a press pulse on released->pressed.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable_n;
  logic [CNT_W-1:0] cnt;

  // Bring the raw asynchronous level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a level change only after it holds long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      stable_n    <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync2 == stable_n) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt         <= '0;
        stable_n    <= sync2;
        press_pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = ~stable_n;

endmodule

// File: rtl/snake_dir_input.sv
// Button-to-heading front end for the snake core.
// Queues one legal turn and commits it on game_tick.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 19,
  parameter dir_t INIT_DIR        = 2'd1
) (
  input  logic       clk_master,
  input  logic       reset_master,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       game_tick,
  output dir_t       dir,
  output logic       dir_changed,
  output logic       pending_valid,
  output logic [3:0] btn_state
);

  logic [3:0] raw_n;
  logic [3:0] press;
  dir_t       pending_dir;
  dir_t       cand;
  dir_t       ref_dir;
  logic       any_press;
  logic       commit;
  logic       accept;

  // Bit index equals the heading code: up,right,down,left.
  assign raw_n = {left, down, right, up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk         (clk_master),
      .rst         (reset_master),
      .btn_n       (raw_n[i]),
      .level       (btn_state[i]),
      .press_pulse (press[i])
    );
  end

  // Pick one press per cycle: up > right > down > left.
  always_comb begin
    cand      = DIR_UP;
    any_press = |press;
    priority case (1'b1)
      press[0]: cand = DIR_UP;
      press[1]: cand = DIR_RIGHT;
      press[2]: cand = DIR_DOWN;
      press[3]: cand = DIR_LEFT;
      default:  cand = DIR_UP;
    endcase
  end

  // Judge the press against the heading that will hold next.
  always_comb begin
    commit  = game_tick & pending_valid;
    ref_dir = commit ? pending_dir : dir;
    accept  = any_press &&
              (cand != ref_dir) &&
              (cand != opposite(ref_dir));
  end

  // Commit on tick first, then queue any accepted press.
  always_ff @(posedge clk_master) begin
    if (reset_master) begin
      dir           <= INIT_DIR;
      dir_changed   <= 1'b0;
      pending_dir   <= INIT_DIR;
      pending_valid <= 1'b0;
    end else begin
      dir_changed <= 1'b0;
      if (commit) begin
        dir           <= pending_dir;
        dir_changed   <= 1'b1;
        pending_valid <= 1'b0;
      end
      if (accept) begin
        pending_dir   <= cand;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input with a short debounce.
// Phase table plus hand sequences, queue-based checking.
module tb_snake_dir_input;
  import snake_pkg::*;

  logic       clk_master = 1'b0;
  logic       reset_master;
  logic       left, right, up, down;
  logic       game_tick;
  dir_t       dir;
  logic       dir_changed;
  logic       pending_valid;
  logic [3:0] btn_state;

  int checks = 0;
  int errors = 0;

  snake_dir_input #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .INIT_DIR        (2'd1)
  ) dut (
    .clk_master    (clk_master),
    .reset_master  (reset_master),
    .left          (left),
    .right         (right),
    .up            (up),
    .down          (down),
    .game_tick     (game_tick),
    .dir           (dir),
    .dir_changed   (dir_changed),
    .pending_valid (pending_valid),
    .btn_state     (btn_state)
  );

  always #5 clk_master = ~clk_master;

  // btn_n order {left,down,right,up}, 1 = released.
  typedef struct {
    logic       rst;
    logic [3:0] btn_n;
    int         n;
    logic       tick;
    logic [1:0] e_dir;
    logic       e_pv;
    logic       e_chg;
    logic [3:0] e_bs;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] e_dir;
    logic       e_pv;
    logic       e_chg;
    logic [3:0] e_bs;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic drive(input logic r, input logic [3:0] b,
                       input logic t);
    reset_master = r;
    {left, down, right, up} = b;
    game_tick = t;
  endtask

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    logic seen;
    int   lat;

    //        rst  btn_n  n  tick dir pv  chg  bs
    tbl.push_back('{1'b1, 4'hF,  2, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b1, 4'hF,  1, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hF, 20, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hE,  5, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hE,  1, 1'b0, 2'd1, 1'b0, 1'b0, 4'h1});
    tbl.push_back('{1'b0, 4'hE,  1, 1'b0, 2'd1, 1'b1, 1'b0, 4'h1});
    tbl.push_back('{1'b0, 4'hE, 13, 1'b1, 2'd0, 1'b0, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'hE,  1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h1});
    tbl.push_back('{1'b1, 4'hF,  2, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'h7,  7, 1'b0, 2'd1, 1'b0, 1'b0, 4'h8});
    tbl.push_back('{1'b0, 4'h7,  3, 1'b1, 2'd1, 1'b0, 1'b0, 4'h8});
    tbl.push_back('{1'b1, 4'hF,  2, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hE,  7, 1'b0, 2'd1, 1'b1, 1'b0, 4'h1});
    tbl.push_back('{1'b0, 4'hB,  7, 1'b0, 2'd1, 1'b1, 1'b0, 4'h4});
    tbl.push_back('{1'b0, 4'hB,  1, 1'b1, 2'd2, 1'b0, 1'b1, 4'h4});
    tbl.push_back('{1'b1, 4'hF,  2, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hE,  3, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hF, 10, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b1, 4'hF,  2, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hE,  7, 1'b0, 2'd1, 1'b1, 1'b0, 4'h1});
    tbl.push_back('{1'b0, 4'h7,  6, 1'b0, 2'd1, 1'b1, 1'b0, 4'h8});
    tbl.push_back('{1'b0, 4'h7,  1, 1'b1, 2'd0, 1'b1, 1'b1, 4'h8});
    tbl.push_back('{1'b0, 4'h7,  3, 1'b1, 2'd3, 1'b0, 1'b1, 4'h8});
    tbl.push_back('{1'b0, 4'hE,  7, 1'b0, 2'd3, 1'b1, 1'b0, 4'h1});
    tbl.push_back('{1'b1, 4'hE,  1, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hF, 10, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hD,  7, 1'b0, 2'd1, 1'b0, 1'b0, 4'h2});
    tbl.push_back('{1'b0, 4'hF,  7, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'hC,  7, 1'b0, 2'd1, 1'b1, 1'b0, 4'h3});
    tbl.push_back('{1'b0, 4'hC,  1, 1'b1, 2'd0, 1'b0, 1'b1, 4'h3});

    drive(1'b1, 4'hF, 1'b0);
    @(negedge clk_master);

    foreach (tbl[k]) begin
      sb.push_back('{k, tbl[k].e_dir, tbl[k].e_pv,
                     tbl[k].e_chg, tbl[k].e_bs});
      for (int i = 0; i < tbl[k].n; i++) begin
        drive(tbl[k].rst, tbl[k].btn_n,
              tbl[k].tick && (i == tbl[k].n - 1));
        @(negedge clk_master);
      end
      game_tick = 1'b0;
      e = sb.pop_front();
      check($sformatf("v%0d.dir", e.idx), 8'(dir), 8'(e.e_dir));
      check($sformatf("v%0d.pending_valid", e.idx),
            8'(pending_valid), 8'(e.e_pv));
      check($sformatf("v%0d.dir_changed", e.idx),
            8'(dir_changed), 8'(e.e_chg));
      check($sformatf("v%0d.btn_state", e.idx),
            8'(btn_state), 8'(e.e_bs));
    end

    // Idle after reset: dir_changed must never pulse.
    drive(1'b1, 4'hF, 1'b0);
    @(negedge clk_master);
    drive(1'b0, 4'hF, 1'b0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk_master);
      seen |= dir_changed;
    end
    check("idle.dir_changed_seen", 8'(seen), 8'd0);

    // Press latency from raw edge to debounced level.
    drive(1'b1, 4'hF, 1'b0);
    @(negedge clk_master);
    drive(1'b0, 4'hE, 1'b0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_master);
      if (btn_state[0]) begin
        lat = k;
        break;
      end
    end
    check("latency.up_level", 8'(lat), 8'd6);

    drive(1'b0, 4'hF, 1'b0);
    @(negedge clk_master);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
